// File: rtl/booth_prod_accum.sv
// Purpose: signed multiply-accumulate back end that sums a programmed batch of Booth products.
// Latency: the result is valid one cycle after the last product transfer; a zero-length batch is valid one cycle after start.
// Backpressure: prod_ready is high only while accumulating; the result is held in DONE until res_ready, with a back-to-back restart allowed.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, len, busy      batch control: start a batch of len products; busy while a batch is open
//   prod, prod_valid/rdy  signed product stream from the multiplier
//   res, res_ovf          accumulated result and sticky signed-overflow flag
//   res_valid/res_ready   result handshake
module booth_prod_accum #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 72,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  res,
   output logic              res_ovf,
   output logic              res_valid,
   input  logic              res_ready
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   target;
   logic               ovf;

   logic [ACC_W-1:0]   pext;
   logic [ACC_W-1:0]   sum;
   logic               add_ovf;
   logic               xfer;
   logic               last;
   logic               take_start;

   // Two's-complement sign extension of the product to the accumulator width.
   assign pext = ACC_W'($signed(prod));
   assign sum  = acc + pext;

   // Signed overflow: both addends share a sign and the sum's sign differs from it.
   assign add_ovf = (acc[ACC_W-1] == pext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

   assign xfer = (state == ACC) && prod_valid;

   // target is never zero in ACC, so target-1 cannot underflow and cnt stops
   // at target-1 before it could wrap.
   assign last = (cnt == target - LEN_W'(1));

   // start is honoured in IDLE, or in DONE on the cycle the result is consumed.
   assign take_start = start && ((state == IDLE) || ((state == DONE) && res_ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         target     <= '0;
         ovf        <= 1'b0;
         res        <= '0;
         res_ovf    <= 1'b0;
         prod_ready <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
      end else if (take_start) begin
         acc    <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         target <= len;
         busy   <= 1'b1;
         if (len != '0) begin
            state      <= ACC;
            prod_ready <= 1'b1;
            res_valid  <= 1'b0;
         end else begin
            // Empty batch goes straight to DONE with a zero result.
            state      <= DONE;
            res        <= '0;
            res_ovf    <= 1'b0;
            prod_ready <= 1'b0;
            res_valid  <= 1'b1;
         end
      end else if ((state == DONE) && res_ready) begin
         state     <= IDLE;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (xfer) begin
         acc <= sum;
         cnt <= cnt + LEN_W'(1);
         ovf <= ovf | add_ovf;
         if (last) begin
            // Result registers take the post-add values directly.
            state      <= DONE;
            res        <= sum;
            res_ovf    <= ovf | add_ovf;
            prod_ready <= 1'b0;
            res_valid  <= 1'b1;
         end
      end else if ((state != IDLE) && (state != ACC) && (state != DONE)) begin
         // Unused encoding: recover to a quiet IDLE.
         state      <= IDLE;
         prod_ready <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
      end
   end

endmodule
